disp_src_arbiter: RTL and testbench

DISP_SRC_ARBITER -- requirements
Module: disp_src_arbiter

---
 rtl/disp_src_arbiter.sv | 106 ++++++++++
 tb/tb_disp_src_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/disp_src_arbiter.sv
// Display source arbiter: round-robin grant of one of four requesters to the
// display, with a minimum dwell time, a rotation lock and a manual override.
module disp_src_arbiter #(
  parameter int unsigned DWELL = 25000000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   req_i,
  input  logic [127:0] data_i,
  input  logic         lock_i,
  input  logic         force_en_i,
  input  logic [1:0]   force_sel_i,
  output logic [3:0]   gnt_o,
  output logic [31:0]  disp_data_o,
  output logic         disp_valid_o,
  output logic         switch_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  localparam logic [31:0] CNT_MAX = DWELL - 32'd1;

  logic [1:0]  state, nxt_state;
  logic [1:0]  rr, nxt_rr;
  logic [1:0]  hold_idx, nxt_idx;
  logic [31:0] cnt, nxt_cnt;
  logic [3:0]  nxt_gnt;
  logic [3:0]  others;
  logic [2:0]  win;
  logic        arb;

  // {found, index} of the first requester at or after ptr, wrapping 3->0
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] i;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      i = ptr + 2'(k);
      if (!res[2] && req[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  always_comb begin
    win       = rr_pick(req_i, rr);
    others    = req_i & ~(4'b0001 << hold_idx);
    nxt_state = state;
    nxt_idx   = hold_idx;
    nxt_rr    = rr;
    nxt_cnt   = cnt;
    arb       = 1'b0;

    // Priority: force, then release, then rotate, then hold
    if (force_en_i) begin
      nxt_state = S_FORCE;
      nxt_idx   = force_sel_i;
    end else if (state == S_DWELL) begin
      if (!req_i[hold_idx])
        arb = 1'b1;
      else if (cnt == CNT_MAX && !lock_i && others != 4'b0000)
        arb = 1'b1;
      else if (cnt < CNT_MAX)
        nxt_cnt = cnt + 32'd1;
    end else begin
      arb = 1'b1;
    end

    if (arb) begin
      if (win[2]) begin
        nxt_state = S_DWELL;
        nxt_idx   = win[1:0];
        nxt_rr    = win[1:0] + 2'd1;
        nxt_cnt   = 32'd0;
      end else begin
        nxt_state = S_IDLE;
      end
    end

    nxt_gnt = (nxt_state == S_IDLE) ? 4'b0000 : (4'b0001 << nxt_idx);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rr           <= 2'd0;
      hold_idx     <= 2'd0;
      cnt          <= 32'd0;
      gnt_o        <= 4'b0000;
      disp_data_o  <= 32'd0;
      disp_valid_o <= 1'b0;
      switch_o     <= 1'b0;
    end else begin
      state        <= nxt_state;
      rr           <= nxt_rr;
      hold_idx     <= nxt_idx;
      cnt          <= nxt_cnt;
      gnt_o        <= nxt_gnt;
      disp_data_o  <= (nxt_gnt == 4'b0000) ? 32'd0 : data_i[{nxt_idx, 5'b00000} +: 32];
      disp_valid_o <= (nxt_gnt != 4'b0000);
      switch_o     <= (nxt_gnt != gnt_o);
    end
  end

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Self-checking bench for disp_src_arbiter (DWELL=4): directed scenarios plus
// randomized traffic compared against a behavioural arbitration model.
module tb_disp_src_arbiter;

  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   req_i = '0;
  logic [127:0] data_i = '0;
  logic         lock_i = 1'b0;
  logic         force_en_i = 1'b0;
  logic [1:0]   force_sel_i = '0;
  logic [3:0]   gnt_o;
  logic [31:0]  disp_data_o;
  logic         disp_valid_o;
  logic         switch_o;

  int errors = 0;
  int checks = 0;

  // Reference model: current holder (-1 = none), forced flag, pointer, dwell age
  int          m_idx = -1;
  bit          m_forced = 0;
  int          m_rr = 0;
  int          m_cnt = 0;
  logic [3:0]  e_gnt = '0;
  logic [31:0] e_data = '0;
  logic        e_sw = 1'b0;

  disp_src_arbiter #(.DWELL(D)) dut (
    .clk(clk), .rstn(rstn), .req_i(req_i), .data_i(data_i), .lock_i(lock_i),
    .force_en_i(force_en_i), .force_sel_i(force_sel_i), .gnt_o(gnt_o),
    .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o), .switch_o(switch_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_idx = -1; m_forced = 0; m_rr = 0; m_cnt = 0;
    e_gnt = '0; e_data = '0; e_sw = 1'b0;
  endfunction

  function automatic void modelArbitrate();
    int w;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && req_i[(m_rr + k) % 4]) w = (m_rr + k) % 4;
    if (w >= 0) begin
      m_idx = w; m_rr = (w + 1) % 4; m_cnt = 0;
    end else begin
      m_idx = -1;
    end
  endfunction

  function automatic void modelStep();
    logic [3:0] prev;
    prev = e_gnt;
    if (force_en_i) begin
      m_idx = int'(force_sel_i); m_forced = 1;
    end else if (m_forced || m_idx < 0) begin
      m_forced = 0;
      modelArbitrate();
    end else if (!req_i[m_idx]) begin
      modelArbitrate();
    end else if (m_cnt == D - 1 && !lock_i && (req_i & ~(4'b0001 << m_idx)) != 0) begin
      modelArbitrate();
    end else if (m_cnt < D - 1) begin
      m_cnt++;
    end
    e_gnt  = (m_idx < 0) ? 4'b0000 : (4'b0001 << m_idx);
    e_data = (m_idx < 0) ? 32'd0 : data_i[32*m_idx +: 32];
    e_sw   = (e_gnt != prev);
  endfunction

  // Called at a negedge: drive inputs, advance one edge, compare, return at next negedge
  task automatic applyStimulus(input logic [3:0] req, input logic lock, input logic fen,
                               input logic [1:0] fsel, input logic [127:0] data, input string tag);
    req_i = req; lock_i = lock; force_en_i = fen; force_sel_i = fsel; data_i = data;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput({tag, ".gnt"},   {28'd0, gnt_o}, {28'd0, e_gnt});
    checkOutput({tag, ".data"},  disp_data_o, e_data);
    checkOutput({tag, ".valid"}, {31'd0, disp_valid_o}, {31'd0, (e_gnt != 4'b0000)});
    checkOutput({tag, ".sw"},    {31'd0, switch_o}, {31'd0, e_sw});
    @(negedge clk);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    req_i = '0; lock_i = 1'b0; force_en_i = 1'b0; force_sel_i = '0;
    modelReset();
    #1;
    checkOutput("rst.gnt",   {28'd0, gnt_o}, 32'd0);
    checkOutput("rst.valid", {31'd0, disp_valid_o}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [127:0] words;
  logic [3:0]   r;

  initial begin
    words = {32'h44444444, 32'hCAFEF00D, 32'h22222222, 32'h12345678};
    @(negedge clk);
    doReset();

    // Single requester: first grant one edge later with switch pulse
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0, words, "single");
    checkOutput("single.gnt0", {28'd0, gnt_o}, 32'h1);
    checkOutput("single.word0", disp_data_o, 32'h12345678);
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0, words, "single2");
    checkOutput("single.swoff", {31'd0, switch_o}, 32'd0);

    // Full contention: each grant held exactly D cycles
    doReset();
    for (int e = 1; e <= 17; e++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 2'd0, words, "rr");
      checkOutput("rr.seq", {28'd0, gnt_o}, 32'(4'b0001 << (((e - 1) / D) % 4)));
    end

    // Lock holds the grant until released
    doReset();
    for (int e = 0; e < 22; e++) begin
      applyStimulus(4'b0011, 1'b1, 1'b0, 2'd0, words, "lock");
      checkOutput("lock.hold", {28'd0, gnt_o}, 32'h1);
    end
    applyStimulus(4'b0011, 1'b0, 1'b0, 2'd0, words, "unlock");
    checkOutput("unlock.gnt", {28'd0, gnt_o}, 32'h2);

    // Early release to remaining requester, then to idle
    doReset();
    applyStimulus(4'b0101, 1'b0, 1'b0, 2'd0, words, "rel");
    applyStimulus(4'b0101, 1'b0, 1'b0, 2'd0, words, "rel");
    applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0, words, "rel");
    checkOutput("rel.gnt2", {28'd0, gnt_o}, 32'h4);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, words, "rel");
    checkOutput("rel.idle", {28'd0, gnt_o}, 32'h0);

    // Manual override with no requests
    doReset();
    applyStimulus(4'b0000, 1'b0, 1'b1, 2'd2, words, "force");
    checkOutput("force.gnt", {28'd0, gnt_o}, 32'h4);
    checkOutput("force.word", disp_data_o, 32'hCAFEF00D);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd2, words, "unforce");
    checkOutput("unforce.gnt", {28'd0, gnt_o}, 32'h0);

    // Asynchronous reset in the middle of a dwell
    doReset();
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0, words, "pre");
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0, words, "pre");
    #2 rstn = 1'b0;
    #1;
    checkOutput("async.gnt",   {28'd0, gnt_o}, 32'd0);
    checkOutput("async.data",  disp_data_o, 32'd0);
    checkOutput("async.valid", {31'd0, disp_valid_o}, 32'd0);
    checkOutput("async.sw",    {31'd0, switch_o}, 32'd0);
    modelReset();
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(4'b1000, 1'b0, 1'b0, 2'd0, words, "post");
    checkOutput("post.gnt", {28'd0, gnt_o}, 32'h8);

    // Randomized traffic against the model
    doReset();
    for (int n = 0; n < 400; n++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      applyStimulus(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                    2'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom}, "rand");
      checkOutput("rand.onehot", {31'd0, $onehot0(gnt_o)}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
